// File: rtl/conv_encoder_tx.sv
// Rate-1/2, K=3 convolutional encoder (G0=7, G1=5 octal) with optional zero-tail
// flush and a registered valid/ready symbol output.
module conv_encoder_tx #(
  parameter int TAIL_EN = 1,
  parameter int FCNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_i,
  input  logic              valid_i,
  input  logic              last_i,
  output logic              ready_o,
  output logic [1:0]        sym_o,
  output logic              sym_valid_o,
  output logic              sym_last_o,
  input  logic              sym_ready_i,
  output logic              busy_o,
  output logic [FCNT_W-1:0] frame_cnt_o
);

  // state    | meaning
  // ST_DATA  | accepting payload bits
  // ST_TAIL1 | emitting first zero tail symbol
  // ST_TAIL2 | emitting final zero tail symbol (flagged last)
  typedef enum logic [1:0] {
    ST_DATA  = 2'd0,
    ST_TAIL1 = 2'd1,
    ST_TAIL2 = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          enc_q, enc_d;
  logic [1:0]          sym_q, sym_d;
  logic                sym_valid_q, sym_valid_d;
  logic                sym_last_q, sym_last_d;
  logic                busy_q, busy_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic                out_free;
  logic                out_hs;
  logic                load;
  logic                u_in;
  logic                last_in;

  // enc[1] = previous bit, enc[0] = the bit before it
  function automatic logic [1:0] encode(input logic u, input logic [1:0] s);
    return {u ^ s[1] ^ s[0], u ^ s[0]};
  endfunction

  always_comb begin
    out_free = !sym_valid_q || sym_ready_i;
    out_hs   = sym_valid_q && sym_ready_i;
    ready_o  = !rst && (state_q == ST_DATA) && out_free;

    state_d = state_q;
    load    = 1'b0;
    u_in    = 1'b0;
    last_in = 1'b0;

    case (state_q)
      ST_DATA: begin
        if (valid_i && ready_o) begin
          load = 1'b1;
          u_in = data_i;
          if (last_i) begin
            if (TAIL_EN != 0) state_d = ST_TAIL1;
            else              last_in = 1'b1;
          end
        end
      end
      ST_TAIL1: begin
        if (out_free) begin
          load    = 1'b1;
          state_d = ST_TAIL2;
        end
      end
      ST_TAIL2: begin
        if (out_free) begin
          load    = 1'b1;
          last_in = 1'b1;
          state_d = ST_DATA;
        end
      end
      default: state_d = ST_DATA;
    endcase
  end

  always_comb begin
    enc_d       = enc_q;
    sym_d       = sym_q;
    sym_valid_d = sym_valid_q;
    sym_last_d  = sym_last_q;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;

    if (out_hs) begin
      sym_valid_d = 1'b0;
      if (sym_last_q) begin
        frame_cnt_d = frame_cnt_q + FCNT_W'(1);
        busy_d      = 1'b0;
      end
    end

    // A load in the same cycle as a handshake replaces the symbol; it must
    // come after the handshake so a new frame's first bit re-asserts busy.
    if (load) begin
      sym_d       = encode(u_in, enc_q);
      sym_valid_d = 1'b1;
      sym_last_d  = last_in;
      enc_d       = {u_in, enc_q[1]};
      if (state_q == ST_DATA) busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_DATA;
      enc_q       <= 2'b00;
      sym_q       <= 2'b00;
      sym_valid_q <= 1'b0;
      sym_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      enc_q       <= enc_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      sym_last_q  <= sym_last_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign sym_o       = sym_q;
  assign sym_valid_o = sym_valid_q;
  assign sym_last_o  = sym_last_q;
  assign busy_o      = busy_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Randomized bench for conv_encoder_tx: a tailed and an untailed instance are
// checked against a bit-history reference model through a symbol queue.
module tb_conv_encoder_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       data_i = 1'b0, last_i = 1'b0;
  logic       valid1 = 1'b0, valid0 = 1'b0;
  logic       sready1 = 1'b1, sready0 = 1'b1;

  logic       ready1, svalid1, slast1, busy1;
  logic [1:0] sym1;
  logic [7:0] cnt1;
  logic       ready0, svalid0, slast0, busy0;
  logic [1:0] sym0;
  logic [7:0] cnt0;

  conv_encoder_tx #(.TAIL_EN(1), .FCNT_W(8)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid1), .last_i(last_i),
    .ready_o(ready1), .sym_o(sym1), .sym_valid_o(svalid1), .sym_last_o(slast1),
    .sym_ready_i(sready1), .busy_o(busy1), .frame_cnt_o(cnt1));

  conv_encoder_tx #(.TAIL_EN(0), .FCNT_W(8)) dut_nt (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid0), .last_i(last_i),
    .ready_o(ready0), .sym_o(sym0), .sym_valid_o(svalid0), .sym_last_o(slast0),
    .sym_ready_i(sready0), .busy_o(busy0), .frame_cnt_o(cnt0));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each instance remembers its last two input bits.
  int         sel = 1;
  int         h1[2], h2[2];
  int         frames_model[2];
  logic [2:0] exp_q[$];
  int         frame_bits[$];
  logic       prev_stall = 1'b0;
  logic [1:0] prev_sym;
  logic       prev_last;
  int         since_last = 0;

  logic       c_ready, c_svalid, c_slast, c_busy;
  logic [1:0] c_sym;
  logic [7:0] c_cnt;
  assign c_ready  = sel ? ready1  : ready0;
  assign c_svalid = sel ? svalid1 : svalid0;
  assign c_slast  = sel ? slast1  : slast0;
  assign c_busy   = sel ? busy1   : busy0;
  assign c_sym    = sel ? sym1    : sym0;
  assign c_cnt    = sel ? cnt1    : cnt0;

  task automatic model_bit(input int u, input logic lst);
    int g0, g1;
    g0 = (u + h1[sel] + h2[sel]) % 2;
    g1 = (u + h2[sel]) % 2;
    exp_q.push_back({g0[0], g1[0], lst});
    h2[sel] = h1[sel];
    h1[sel] = u;
  endtask

  task automatic model_frame();
    int n;
    n = frame_bits.size();
    for (int i = 0; i < n; i++)
      model_bit(frame_bits[i], (sel == 0) && (i == n - 1));
    if (sel == 1) begin
      model_bit(0, 1'b0);
      model_bit(0, 1'b1);
    end
  endtask

  task automatic set_bits(input logic [15:0] v, input int n);
    frame_bits.delete();
    for (int i = n - 1; i >= 0; i--) frame_bits.push_back(int'(v[i]));
  endtask

  // mode 0: sym_ready always high; mode 1: random backpressure.
  // abort: return right after the last bit is accepted (tail still pending).
  task automatic send_frame(input int mode, input bit abort);
    int         bi, n, budget;
    bit         done, v;
    logic       sr;
    logic [2:0] e;
    bi = 0; budget = 2000; done = 0;
    n = frame_bits.size();
    model_frame();
    while (!done) begin
      @(negedge clk);
      sr = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      sready1 = sel ? sr : 1'b1;
      sready0 = sel ? 1'b1 : sr;
      v = (bi < n);
      if (v) begin
        data_i = frame_bits[bi][0];
        last_i = (bi == n - 1);
      end else begin
        data_i = 1'($urandom_range(0, 1));
        last_i = 1'($urandom_range(0, 1));
      end
      valid1 = (sel == 1) && v;
      valid0 = (sel == 0) && v;
      #1;
      if (prev_stall) begin
        check_eq("stall_valid", c_svalid, 1);
        check_eq("stall_sym", c_sym, prev_sym);
        check_eq("stall_last", c_slast, prev_last);
      end
      if (bi == 0) check_eq("busy_idle", c_busy, 0);
      else if (exp_q.size() > 0) check_eq("busy_frame", c_busy, 1);
      if (sel == 1 && since_last > 0) begin
        if (since_last <= 2) check_eq("ready_tail_bubble", c_ready, 0);
        else if (mode == 0) check_eq("ready_after_tail", c_ready, 1);
        since_last = (since_last >= 3) ? 0 : since_last + 1;
      end
      if (c_svalid && sr) begin
        if (exp_q.size() == 0) check_eq("spurious_symbol", c_svalid, 0);
        else begin
          e = exp_q.pop_front();
          check_eq("sym", c_sym, e[2:1]);
          check_eq("sym_last", c_slast, e[0]);
          if (e[0]) frames_model[sel]++;
        end
      end
      prev_stall = c_svalid && !sr;
      prev_sym   = c_sym;
      prev_last  = c_slast;
      if (v && c_ready) begin
        bi++;
        if (bi == n && sel == 1) since_last = 1;
      end
      @(posedge clk);
      #1;
      budget--;
      done = (bi == n) && (abort || exp_q.size() == 0);
      if (!done && budget == 0) begin
        check_eq("frame_timeout", exp_q.size(), 0);
        done = 1;
      end
    end
    valid1 = 1'b0;
    valid0 = 1'b0;
    if (!abort) begin
      @(negedge clk);
      check_eq("frame_cnt", c_cnt, frames_model[sel] % 256);
      check_eq("busy_done", c_busy, 0);
      check_eq("valid_drained", c_svalid, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid1 = 1'b0; valid0 = 1'b0;
    sready1 = 1'b1; sready0 = 1'b1;
    #1;
    check_eq("ready_in_reset", ready1, 0);
    check_eq("ready_nt_in_reset", ready0, 0);
    @(negedge clk);
    check_eq("rst_sym_valid", svalid1, 0);
    check_eq("rst_sym_last", slast1, 0);
    check_eq("rst_sym", sym1, 0);
    check_eq("rst_busy", busy1, 0);
    check_eq("rst_frame_cnt", cnt1, 0);
    check_eq("rst_nt_sym_valid", svalid0, 0);
    check_eq("rst_nt_frame_cnt", cnt0, 0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      h1[i] = 0; h2[i] = 0; frames_model[i] = 0;
    end
    exp_q.delete();
    prev_stall = 1'b0;
    since_last = 0;
  endtask

  initial begin
    int len;
    do_reset();

    sel = 1;
    set_bits(16'b1011, 4); send_frame(0, 0);
    set_bits(16'b1, 1);    send_frame(0, 0);
    set_bits(16'b1011, 4); send_frame(1, 0);

    // reset while the first tail symbol is pending
    set_bits(16'b1011, 4); send_frame(0, 1);
    do_reset();
    set_bits(16'b1011, 4); send_frame(0, 0);

    sel = 0;
    set_bits(16'b11, 2); send_frame(0, 0);
    set_bits(16'b01, 2); send_frame(1, 0);

    // 255 more frames bring the tailed instance's counter to 256 -> wraps to 0
    sel = 1;
    for (int f = 0; f < 255; f++) begin
      len = $urandom_range(1, 12);
      set_bits(16'($urandom_range(0, 65535)), len);
      send_frame($urandom_range(0, 1), 0);
    end
    check_eq("frame_cnt_wrap", cnt1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
